sa_sequencer: RTL and testbench
===============================

Name: sa_sequencer

Overview:
- Control FSM that runs one complete matrix multiply C = A x B on the memA / memB / systolic_array datapath.
- Accepts DIM row-pairs (one A row and one B row per beat) over a valid/ready stream and writes them into memA and memB.
- Steps the array until the skewed wavefront fully drains, streams the DIM rows of C out over a valid/ready stream, then zeroes C so the next job starts clean.

Parameters:
- BITS_AB, 8, width of each A and B element.
- BITS_C, 16, width of each C element.
- DIM, 8, array dimension (square, DIM x DIM).
- ROWBITS, $clog2(DIM), width of row indices.

Ports:
- clk, input, 1, system clock. Single clock domain, rising edge.
- rst_n, input, 1, reset, asynchronous assert, active-low.
- start, input, 1, begin a job. Sampled only in IDLE.
- busy, output, 1, high in any state other than IDLE.
- done, output, 1, one-cycle pulse on the final CLEAR cycle.
- in_valid, input, 1, ab_in carries a valid row-pair.
- in_ready, output, 1, high only in LOAD.
- a_in, input, DIM*BITS_AB, A row; element k is at bits [k*BITS_AB +: BITS_AB].
- b_in, input, DIM*BITS_AB, B row; same packing as a_in.
- c_out_valid, output, 1, c_out carries a C row (READ state).
- c_out_ready, input, 1, consumer accepts the current C row.
- c_out, output, DIM*BITS_C, C row; combinational passthrough of sa_cout.
- c_out_row, output, ROWBITS, index of the C row on c_out.
- dp_en, output, 1, shared enable for memA, memB and systolic_array.
- mema_wren, output, 1, memA row write enable.
- mema_row, output, ROWBITS, memA target row (Arow).
- mema_din, output, DIM*BITS_AB, memA row data (Ain).
- memb_din, output, DIM*BITS_AB, memB input row (Bin).
- sa_wren, output, 1, systolic_array C write enable.
- sa_crow, output, ROWBITS, systolic_array C row select.
- sa_cin, output, DIM*BITS_C, systolic_array C write data. Always zero.
- sa_cout, input, DIM*BITS_C, systolic_array C row output for sa_crow.

Behaviour:
- States: IDLE, LOAD, DRAIN, READ, CLEAR. A single counter cnt of width $clog2(2*DIM)+1 is cleared on every state entry.
- Reset (asynchronous):
  - State goes to IDLE and cnt to 0.
  - All outputs read 0: busy, done, in_ready, c_out_valid, dp_en, mema_wren, sa_wren, row indices, data buses.
  - Reset mid-job abandons the job. No output event follows. The datapath shares rst_n, so its contents are also zeroed.
- Outputs are decoded from state/cnt. The only combinational input paths are:
  - LOAD: dp_en, mema_wren and memb_din depend on in_valid.
  - READ: c_out is a passthrough of sa_cout.
- IDLE:
  - All strobes 0.
  - start=1 moves to LOAD on the next edge. start=0 stays in IDLE.
- LOAD:
  - in_ready=1.
  - Beat (in_valid & in_ready):
    - dp_en=1, mema_wren=1, mema_row=cnt, mema_din=a_in, memb_din=b_in.
    - cnt increments.
  - No beat: dp_en=0, mema_wren=0, memb_din=0. The datapath freezes, which is a legal stall.
  - The beat with cnt==DIM-1 moves to DRAIN.
- DRAIN:
  - dp_en=1, mema_wren=0, memb_din=0 for exactly 2*DIM cycles (cnt 0..2*DIM-1), then READ.
  - Total dp_en cycles per job is exactly 3*DIM.
- READ:
  - dp_en=0, c_out_valid=1, sa_crow=c_out_row=cnt, c_out=sa_cout.
  - On c_out_ready, cnt increments. Holding c_out_ready=0 holds the row indefinitely, with c_out stable.
  - The handshake at cnt==DIM-1 moves to CLEAR.
- CLEAR:
  - sa_wren=1, sa_cin=0, sa_crow=cnt, dp_en=0 for DIM cycles.
  - done=1 in the cycle with cnt==DIM-1, then IDLE.
- start is ignored outside IDLE; it is never queued.
- Minimum latency, start edge to done cycle, with no stalls: 1 + DIM + 2*DIM + DIM + DIM cycles, i.e. 41 cycles at DIM=8.
- mema_row and sa_crow wrap naturally at ROWBITS. cnt never exceeds its terminal value in any state.

Test Plan:
- Basic job: DIM=8, A=identity, B[r][c]=r*8+c, streamed with in_valid held high, c_out_ready=1 -> c_out rows 0..7 equal B row-for-row, in row order. dp_en high exactly 24 cycles. done asserted 41 cycles after start is sampled.
- Load stalls: same data with in_valid deasserted for 3 cycles after beats 2 and 5 -> identical C. dp_en and mema_wren low during each gap. Total dp_en count still 24.
- Read backpressure: A[r][c]=1, B[r][c]=2 with c_out_ready toggling 1,0,0,1… -> every C element reads 16. c_out_row advances only on handshake. c_out is stable while stalled.
- Start while busy plus back-to-back jobs:
  - Pulse start during DRAIN -> ignored, done pulses once.
  - Then run a second job with A=2*identity, B[r][c]=r+c -> C[r][c]=2*(r+c). This confirms CLEAR left no residue from the first job.
- Reset mid-job: assert rst_n=0 during DRAIN cycle 5 -> all outputs 0 immediately (asynchronously). After release, the basic job repeated gives correct C.
- Signed extremes: A all -128, B all 127 -> each C element is -130048 truncated to BITS_C=16, i.e. 0x0400 (1024). This checks that the sequencer passes sa_cout through untouched.

Source files
------------

// File: rtl/sa_sequencer.sv
// Control FSM for one C = A x B job on the memA/memB/systolic_array datapath:
// load DIM row-pairs, drain the skewed wavefront, stream C rows out, then zero C.
module sa_sequencer #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8,
  parameter int ROWBITS = $clog2(DIM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIM*BITS_AB-1:0]  a_in,
  input  logic [DIM*BITS_AB-1:0]  b_in,
  output logic                    c_out_valid,
  input  logic                    c_out_ready,
  output logic [DIM*BITS_C-1:0]   c_out,
  output logic [ROWBITS-1:0]      c_out_row,
  output logic                    dp_en,
  output logic                    mema_wren,
  output logic [ROWBITS-1:0]      mema_row,
  output logic [DIM*BITS_AB-1:0]  mema_din,
  output logic [DIM*BITS_AB-1:0]  memb_din,
  output logic                    sa_wren,
  output logic [ROWBITS-1:0]      sa_crow,
  output logic [DIM*BITS_C-1:0]   sa_cin,
  input  logic [DIM*BITS_C-1:0]   sa_cout
);

  localparam int CNTW = $clog2(2*DIM) + 1;
  localparam logic [CNTW-1:0] LAST_ROW   = CNTW'(DIM - 1);
  localparam logic [CNTW-1:0] LAST_DRAIN = CNTW'(2*DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_READ,
    S_CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [ROWBITS-1:0] row;
  logic              beat;

  assign row  = cnt_q[ROWBITS-1:0];
  assign beat = (state_q == S_LOAD) && in_valid;

  // cnt is cleared on every state entry, so each state counts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (cnt_q == LAST_ROW) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == LAST_DRAIN) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (c_out_ready) begin
          if (cnt_q == LAST_ROW) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST_ROW) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything decodes to zero in IDLE, so the async reset clears all outputs at once.
  always_comb begin
    busy        = (state_q != S_IDLE);
    in_ready    = (state_q == S_LOAD);
    c_out_valid = (state_q == S_READ);
    sa_wren     = (state_q == S_CLEAR);
    done        = (state_q == S_CLEAR) && (cnt_q == LAST_ROW);
    dp_en       = beat || (state_q == S_DRAIN);
    mema_wren   = beat;
    mema_row    = (state_q == S_LOAD) ? row : '0;
    mema_din    = beat ? a_in : '0;
    memb_din    = beat ? b_in : '0;
    c_out       = (state_q == S_READ) ? sa_cout : '0;
    c_out_row   = (state_q == S_READ) ? row : '0;
    sa_crow     = ((state_q == S_READ) || (state_q == S_CLEAR)) ? row : '0;
    sa_cin      = '0;
  end

endmodule

// File: tb/tb_sa_sequencer.sv
// Bench for sa_sequencer: a behavioural datapath model closes the loop and C rows
// are compared against a matrix product computed directly from the stimulus.
module tb_sa_sequencer;

  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;
  localparam int DIM     = 8;
  localparam int ROWBITS = $clog2(DIM);

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   busy, done;
  logic                   in_valid, in_ready;
  logic [DIM*BITS_AB-1:0] a_in, b_in;
  logic                   c_out_valid, c_out_ready;
  logic [DIM*BITS_C-1:0]  c_out;
  logic [ROWBITS-1:0]     c_out_row;
  logic                   dp_en, mema_wren;
  logic [ROWBITS-1:0]     mema_row;
  logic [DIM*BITS_AB-1:0] mema_din, memb_din;
  logic                   sa_wren;
  logic [ROWBITS-1:0]     sa_crow;
  logic [DIM*BITS_C-1:0]  sa_cin, sa_cout;

  always #5 clk = ~clk;

  sa_sequencer #(
    .BITS_AB (BITS_AB),
    .BITS_C  (BITS_C),
    .DIM     (DIM),
    .ROWBITS (ROWBITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .c_out_valid (c_out_valid),
    .c_out_ready (c_out_ready),
    .c_out       (c_out),
    .c_out_row   (c_out_row),
    .dp_en       (dp_en),
    .mema_wren   (mema_wren),
    .mema_row    (mema_row),
    .mema_din    (mema_din),
    .memb_din    (memb_din),
    .sa_wren     (sa_wren),
    .sa_crow     (sa_crow),
    .sa_cin      (sa_cin),
    .sa_cout     (sa_cout)
  );

  int nchecks = 0;
  int nerrs   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus matrices (signed element values).
  int ma[DIM][DIM];
  int mb[DIM][DIM];

  // Datapath model: memA/memB capture, whole product lands once the full 3*DIM
  // enable cycles have elapsed; CLEAR writes overwrite C rows.
  logic [DIM*BITS_AB-1:0] amem[DIM];
  logic [DIM*BITS_AB-1:0] bmem[DIM];
  int cm[DIM][DIM];
  int dpcnt;

  function automatic int dp_prod(input int r, input int c);
    int s = 0;
    for (int k = 0; k < DIM; k++)
      s += $signed(amem[r][k*BITS_AB +: BITS_AB]) * $signed(bmem[k][c*BITS_AB +: BITS_AB]);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dpcnt <= 0;
      for (int i = 0; i < DIM; i++) begin
        amem[i] <= '0;
        bmem[i] <= '0;
        for (int j = 0; j < DIM; j++) cm[i][j] <= 0;
      end
    end else begin
      if (dp_en) begin
        if (mema_wren) amem[mema_row] <= mema_din;
        if (dpcnt < DIM) bmem[dpcnt] <= memb_din;
        if (dpcnt == 3*DIM-1)
          for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) cm[r][c] <= cm[r][c] + dp_prod(r, c);
        dpcnt <= dpcnt + 1;
      end
      if (sa_wren) begin
        for (int c = 0; c < DIM; c++) cm[sa_crow][c] <= $signed(sa_cin[c*BITS_C +: BITS_C]);
        dpcnt <= 0;
      end
    end
  end

  always_comb begin
    sa_cout = '0;
    for (int c = 0; c < DIM; c++) sa_cout[c*BITS_C +: BITS_C] = BITS_C'(cm[sa_crow][c]);
  end

  function automatic logic [DIM*BITS_AB-1:0] pack_row(input int r, input bit is_b);
    logic [DIM*BITS_AB-1:0] v = '0;
    for (int k = 0; k < DIM; k++)
      v[k*BITS_AB +: BITS_AB] = is_b ? BITS_AB'(mb[r][k]) : BITS_AB'(ma[r][k]);
    return v;
  endfunction

  function automatic logic [DIM*BITS_C-1:0] exp_row(input int r);
    logic [DIM*BITS_C-1:0] v = '0;
    for (int c = 0; c < DIM; c++) begin
      int s = 0;
      for (int k = 0; k < DIM; k++) s += ma[r][k] * mb[k][c];
      v[c*BITS_C +: BITS_C] = BITS_C'(s);
    end
    return v;
  endfunction

  task automatic set_basic();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r*8 + c;
      end
  endtask

  task automatic set_fill(input int av, input int bv);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = av;
        mb[r][c] = bv;
      end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, 128'({busy, done, in_ready, c_out_valid, dp_en, mema_wren, sa_wren}), '0);
    check({tag, "_rows"}, 128'({c_out_row, mema_row, sa_crow}), '0);
    check({tag, "_ab"}, 128'({mema_din, memb_din}), '0);
    check({tag, "_c"}, 128'(c_out | sa_cin), '0);
  endtask

  // gmode: 0 no gaps, 1 three-cycle gaps after beats 3 and 6, 2 random gaps.
  // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_job(input int gmode, input int rmode, input bit poke_start, input bit do_reset);
    int beat = 0, rd = 0, gaps = 0, stalls = 0, dpn = 0, wrn = 0, dn = 0;
    int cyc, drain_cyc = 0, gap_left = 0, rsel = 0, lat_exp;
    bit fin = 0, aborted = 0, in_drain, rdy;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 2;
    check("busy_after_start", 128'(busy), 128'(1));
    while (!fin && cyc < 600) begin
      start       = 1'b0;
      in_valid    = 1'b0;
      c_out_ready = 1'b0;
      a_in        = {$urandom, $urandom};
      b_in        = {$urandom, $urandom};
      in_drain    = busy && !in_ready && !c_out_valid && !sa_wren;
      if (in_ready) begin
        bit v;
        case (gmode)
          0: v = 1'b1;
          1: if (gap_left > 0) begin v = 1'b0; gap_left--; end else v = 1'b1;
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        if (v) begin
          in_valid = 1'b1;
          a_in     = pack_row(beat, 1'b0);
          b_in     = pack_row(beat, 1'b1);
        end
      end
      rdy = 1'b0;
      if (c_out_valid) begin
        case (rmode)
          0: rdy = 1'b1;
          1: rdy = ((rsel % 4) == 0) || ((rsel % 4) == 3);
          default: rdy = ($urandom_range(0, 1) == 1);
        endcase
        rsel++;
        c_out_ready = rdy;
      end
      if (poke_start && in_drain && drain_cyc == 3) start = 1'b1;
      if (do_reset && in_drain && drain_cyc == 5) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_idle_busy", 128'(busy), '0);
        aborted = 1'b1;
        break;
      end
      #1;
      check("sa_cin_zero", 128'(sa_cin), '0);
      if (in_valid) begin
        check("beat_en", 128'({dp_en, mema_wren}), 128'(3));
        check("mema_row", 128'(mema_row), 128'(beat));
        check("mema_din", 128'(mema_din), 128'(pack_row(beat, 1'b0)));
        check("memb_din", 128'(memb_din), 128'(pack_row(beat, 1'b1)));
        beat++;
        if (gmode == 1 && (beat == 3 || beat == 6)) gap_left = 3;
      end else if (in_ready) begin
        check("gap_quiet", 128'({dp_en, mema_wren, memb_din}), '0);
        gaps++;
      end
      if (c_out_valid) begin
        check("c_out_row", 128'(c_out_row), 128'(rd));
        check("c_out", 128'(c_out), 128'(exp_row(rd)));
        if (rdy) rd++; else stalls++;
      end
      if (dp_en) dpn++;
      if (sa_wren) wrn++;
      if (done) begin
        dn++;
        lat_exp = 1 + (DIM + gaps) + 2*DIM + (DIM + stalls) + DIM;
        check("latency", 128'(cyc), 128'(lat_exp));
        fin = 1'b1;
      end
      if (in_drain) drain_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
    start       = 1'b0;
    in_valid    = 1'b0;
    c_out_ready = 1'b0;
    if (!aborted) begin
      if (!fin) check("timeout_done", '0, 128'(1));
      check("rows_read", 128'(rd), 128'(DIM));
      check("dp_en_cycles", 128'(dpn), 128'(3*DIM));
      check("sa_wren_cycles", 128'(wrn), 128'(DIM));
      check("done_pulses", 128'(dn), 128'(1));
      check("idle_after", 128'({busy, done}), '0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    in_valid    = 1'b0;
    c_out_ready = 1'b0;
    a_in        = '0;
    b_in        = '0;
    set_basic();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_start", 128'({busy, in_ready, dp_en}), '0);

    set_basic();            run_job(0, 0, 1'b0, 1'b0);
    set_basic();            run_job(1, 0, 1'b0, 1'b0);
    set_fill(1, 2);         run_job(0, 1, 1'b0, 1'b0);
    set_basic();            run_job(0, 0, 1'b1, 1'b0);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = (r == c) ? 2 : 0;
        mb[r][c] = r + c;
      end
    run_job(0, 0, 1'b0, 1'b0);
    set_basic();            run_job(0, 0, 1'b0, 1'b1);
    set_basic();            run_job(0, 0, 1'b0, 1'b0);
    set_fill(-128, 127);    run_job(0, 0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) begin
          ma[r][c] = int'($urandom_range(0, 255)) - 128;
          mb[r][c] = int'($urandom_range(0, 255)) - 128;
        end
      run_job(2, 2, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
